// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Brief    : Stall/flush sequencer for the five-stage pipeline: load-use,
//             branch redirect, fixed-latency MDU freeze and dmem stalls.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
   parameter int MDU_LAT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs1_ID,
   input  logic [4:0]  rs2_ID,
   input  logic        rs1_used_ID,
   input  logic        rs2_used_ID,
   input  logic [4:0]  rd_EX,
   input  logic        memread_EX,
   input  logic        branch_taken_EX,
   input  logic        mdu_start_EX,
   input  logic        dmem_stall,
   input  logic        perf_clr,
   output logic        pc_write,
   output logic        stall_IF_ID,
   output logic        stall_ID_EX,
   output logic        stall_EX_MEM,
   output logic        flush_IF_ID,
   output logic        flush_ID_EX,
   output logic        flush_EX_MEM,
   output logic        mdu_busy,
   output logic        mdu_done,
   output logic [31:0] stall_cycles
);

   localparam logic [0:0] c_RUN      = 1'b0;
   localparam logic [0:0] c_MDU_WAIT = 1'b1;
   localparam logic [3:0] c_CNT_INIT = 4'(MDU_LAT - 1);

   logic [0:0]  r_state;
   logic [0:0]  w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic [31:0] r_stall_cycles;
   logic        w_load_use;

   assign w_load_use = memread_EX && (rd_EX != 5'd0) &&
                       ((rs1_used_ID && (rs1_ID == rd_EX)) ||
                        (rs2_used_ID && (rs2_ID == rd_EX)));

   // Priority chain; reset forces a bubble into every register.
   always_comb begin
      pc_write     = 1'b0;
      stall_IF_ID  = 1'b0;
      stall_ID_EX  = 1'b0;
      stall_EX_MEM = 1'b0;
      flush_IF_ID  = 1'b0;
      flush_ID_EX  = 1'b0;
      flush_EX_MEM = 1'b0;
      mdu_done     = 1'b0;
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;

      if (reset) begin
         flush_IF_ID  = 1'b1;
         flush_ID_EX  = 1'b1;
         flush_EX_MEM = 1'b1;
      end else if (dmem_stall) begin
         stall_IF_ID  = 1'b1;
         stall_ID_EX  = 1'b1;
         stall_EX_MEM = 1'b1;
      end else if (r_state == c_MDU_WAIT) begin
         stall_IF_ID  = 1'b1;
         stall_ID_EX  = 1'b1;
         flush_EX_MEM = 1'b1;
         w_cnt_nxt    = r_cnt - 4'd1;
         if (r_cnt == 4'd1) begin
            mdu_done    = 1'b1;
            w_state_nxt = c_RUN;
         end
      end else if (branch_taken_EX) begin
         pc_write    = 1'b1;
         flush_IF_ID = 1'b1;
         flush_ID_EX = 1'b1;
      end else if (mdu_start_EX) begin
         stall_IF_ID  = 1'b1;
         stall_ID_EX  = 1'b1;
         flush_EX_MEM = 1'b1;
         w_cnt_nxt    = c_CNT_INIT;
         w_state_nxt  = c_MDU_WAIT;
      end else if (w_load_use) begin
         stall_IF_ID = 1'b1;
         flush_ID_EX = 1'b1;
      end else begin
         pc_write = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_RUN;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cycles <= 32'd0;
      end else if (perf_clr) begin
         r_stall_cycles <= 32'd0;
      end else if (!pc_write) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign mdu_busy     = (r_state == c_MDU_WAIT) && !reset;
   assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Brief    : Directed self-checking bench for pipeline_hazard_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs1_ID, rs2_ID, rd_EX;
   logic        rs1_used_ID, rs2_used_ID, memread_EX;
   logic        branch_taken_EX, mdu_start_EX, dmem_stall, perf_clr;
   logic        pc_write, stall_IF_ID, stall_ID_EX, stall_EX_MEM;
   logic        flush_IF_ID, flush_ID_EX, flush_EX_MEM, mdu_busy, mdu_done;
   logic [31:0] stall_cycles;

   int n_checks = 0;
   int n_errors = 0;
   int n_done   = 0;

   // {pc, sIF, sID, sEX, fIF, fID, fEX, busy, done}
   localparam logic [8:0] c_RESET_V = 9'b0_000_111_00;
   localparam logic [8:0] c_RUN_V   = 9'b1_000_000_00;
   localparam logic [8:0] c_LU_V    = 9'b0_100_010_00;
   localparam logic [8:0] c_BR_V    = 9'b1_000_110_00;
   localparam logic [8:0] c_MDU0_V  = 9'b0_110_001_00;
   localparam logic [8:0] c_MDUW_V  = 9'b0_110_001_10;
   localparam logic [8:0] c_MDUD_V  = 9'b0_110_001_11;
   localparam logic [8:0] c_DMEM_V  = 9'b0_111_000_00;
   localparam logic [8:0] c_DMEMB_V = 9'b0_111_000_10;

   logic [8:0] w_ctl;
   assign w_ctl = {pc_write, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
                   flush_IF_ID, flush_ID_EX, flush_EX_MEM, mdu_busy, mdu_done};

   pipeline_hazard_ctrl #(.MDU_LAT(4)) dut (
      .clk(clk), .reset(reset),
      .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
      .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
      .rd_EX(rd_EX), .memread_EX(memread_EX),
      .branch_taken_EX(branch_taken_EX), .mdu_start_EX(mdu_start_EX),
      .dmem_stall(dmem_stall), .perf_clr(perf_clr),
      .pc_write(pc_write),
      .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX), .stall_EX_MEM(stall_EX_MEM),
      .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .flush_EX_MEM(flush_EX_MEM),
      .mdu_busy(mdu_busy), .mdu_done(mdu_done), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Sample controls mid-cycle, then advance to just past the next rising edge.
   task automatic cyc(input string tag, input logic [8:0] exp);
      @(negedge clk);
      check(tag, 32'(w_ctl), 32'(exp));
      check({tag, "_inv"}, 32'({stall_IF_ID, stall_ID_EX, stall_EX_MEM} &
                               {flush_IF_ID, flush_ID_EX, flush_EX_MEM}), 32'd0);
      if (mdu_done) n_done++;
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      rs1_ID = 5'd0; rs2_ID = 5'd0; rd_EX = 5'd0;
      rs1_used_ID = 1'b0; rs2_used_ID = 1'b0; memread_EX = 1'b0;
      branch_taken_EX = 1'b0; mdu_start_EX = 1'b0; dmem_stall = 1'b0; perf_clr = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clr_in();
      #3;
      check("rst_ctl", 32'(w_ctl), 32'(c_RESET_V));
      check("rst_cnt", stall_cycles, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      check("rst_cnt_hold", stall_cycles, 32'd0);
      reset = 1'b0;

      cyc("idle", c_RUN_V);
      check("idle_cnt", stall_cycles, 32'd0);

      // load-use on rs1
      rd_EX = 5'd5; memread_EX = 1'b1; rs1_ID = 5'd5; rs1_used_ID = 1'b1;
      cyc("lu_rs1", c_LU_V);
      check("lu_cnt", stall_cycles, 32'd1);
      memread_EX = 1'b0;
      cyc("lu_clear", c_RUN_V);

      // x0 and unused-source filters
      clr_in(); memread_EX = 1'b1; rd_EX = 5'd0; rs1_used_ID = 1'b1;
      cyc("x0_filter", c_RUN_V);
      clr_in(); memread_EX = 1'b1; rd_EX = 5'd7; rs2_ID = 5'd7; rs1_ID = 5'd3; rs1_used_ID = 1'b1;
      cyc("rs2_unused", c_RUN_V);
      rs2_used_ID = 1'b1;
      cyc("lu_rs2", c_LU_V);
      check("lu2_cnt", stall_cycles, 32'd2);

      // branch beats load-use
      branch_taken_EX = 1'b1;
      cyc("br_prio", c_BR_V);
      check("br_cnt", stall_cycles, 32'd2);

      // plain MDU op
      clr_in(); mdu_start_EX = 1'b1; n_done = 0;
      cyc("mdu_c1", c_MDU0_V);
      mdu_start_EX = 1'b0;
      cyc("mdu_c2", c_MDUW_V);
      cyc("mdu_c3", c_MDUW_V);
      cyc("mdu_c4", c_MDUD_V);
      cyc("mdu_c5", c_RUN_V);
      check("mdu_cnt", stall_cycles, 32'd6);
      check("mdu_done_n", 32'(n_done), 32'd1);

      // MDU op stretched by two dmem stalls
      mdu_start_EX = 1'b1; n_done = 0;
      cyc("mdd_c1", c_MDU0_V);
      mdu_start_EX = 1'b0; dmem_stall = 1'b1;
      cyc("mdd_c2", c_DMEMB_V);
      cyc("mdd_c3", c_DMEMB_V);
      dmem_stall = 1'b0;
      cyc("mdd_c4", c_MDUW_V);
      cyc("mdd_c5", c_MDUW_V);
      cyc("mdd_c6", c_MDUD_V);
      cyc("mdd_c7", c_RUN_V);
      check("mdd_cnt", stall_cycles, 32'd12);
      check("mdd_done_n", 32'(n_done), 32'd1);

      // dmem stall in RUN
      dmem_stall = 1'b1;
      cyc("dmem_run", c_DMEM_V);
      dmem_stall = 1'b0;
      check("dmem_cnt", stall_cycles, 32'd13);

      // perf_clr during a stalled cycle
      memread_EX = 1'b1; rd_EX = 5'd9; rs1_ID = 5'd9; rs1_used_ID = 1'b1; perf_clr = 1'b1;
      cyc("clr_lu", c_LU_V);
      check("clr_cnt", stall_cycles, 32'd0);
      clr_in();

      // reset mid-MDU
      mdu_start_EX = 1'b1; n_done = 0;
      cyc("rmdu_c1", c_MDU0_V);
      mdu_start_EX = 1'b0;
      @(negedge clk);
      check("rmdu_c2", 32'(w_ctl), 32'(c_MDUW_V));
      #2 reset = 1'b1;
      #1;
      check("rmdu_async", 32'(w_ctl), 32'(c_RESET_V));
      check("rmdu_cnt", stall_cycles, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      cyc("rmdu_run1", c_RUN_V);
      cyc("rmdu_run2", c_RUN_V);
      check("rmdu_done_n", 32'(n_done), 32'd0);

      // wrap of the stall counter
      dut.r_stall_cycles = 32'hFFFF_FFFF;
      #1;
      check("wrap_pre", stall_cycles, 32'hFFFF_FFFF);
      memread_EX = 1'b1; rd_EX = 5'd4; rs2_ID = 5'd4; rs2_used_ID = 1'b1;
      cyc("wrap_lu", c_LU_V);
      check("wrap_cnt", stall_cycles, 32'd0);
      clr_in();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
